// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: drain state encoding,
// default FIFO depth and a pointer-width helper.
package uart_pkg;

    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } drain_state_e;

    // Width of a pointer that indexes a power-of-two array of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side push port plus UART-side data port of the transmit FIFO.
// The irq_tx_done signal exists only when UART_TX_FIFO_IRQ_EN is defined.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);

    // Push side: wr_en is a one-cycle strobe with no back-pressure; a strobe
    // seen while full is dropped and flagged in overflow. UART side:
    // uart_dat_we is a single-cycle strobe, uart_dat_di is valid with it, and
    // the FIFO only strobes while uart_send_busy and the divider guard are low.
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     flush;
    logic                     clr_overflow;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     uart_dat_we;
    logic [7:0]               uart_dat_di;
    logic                     uart_send_busy;
    logic                     uart_div_wr;
    drain_state_e             state;
`ifdef UART_TX_FIFO_IRQ_EN
    logic                     irq_tx_done;
`endif

    modport master (
        output wr_en, wr_data, flush, clr_overflow, uart_send_busy, uart_div_wr,
        input  full, empty, level, overflow, uart_dat_we, uart_dat_di, state
`ifdef UART_TX_FIFO_IRQ_EN
        , input irq_tx_done
`endif
    );

    modport slave (
        input  wr_en, wr_data, flush, clr_overflow, uart_send_busy, uart_div_wr,
        output full, empty, level, overflow, uart_dat_we, uart_dat_di, state
`ifdef UART_TX_FIFO_IRQ_EN
        , output irq_tx_done
`endif
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Byte storage for the transmit FIFO: one synchronous write port and an
// asynchronous read port addressed by the read pointer.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO ahead of simpleuart, draining one byte per idle UART frame.
// Optional tx-done interrupt output is enabled by defining UART_TX_FIFO_IRQ_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_fifo_if.slave bus
);

    localparam int AW = ptr_width(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic          div_guard;
    logic          dat_we_q;
    logic [7:0]    dat_di_q;
    logic [7:0]    head_byte;
    logic          full_w;
    logic          empty_w;
    logic          push_ok;
    logic          pop;

    drain_state_e  state_q;
    drain_state_e  state_d;

    assign full_w  = (level_q == LW'(DEPTH));
    assign empty_w = (level_q == '0);
    // Full is judged on the pre-edge level, so a same-cycle pop never rescues a push.
    assign push_ok = bus.wr_en && !full_w && !bus.flush;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (head_byte)
    );

    // Drain FSM: the pop happens on the IDLE->ISSUE edge, so the byte is
    // already committed to the UART even if a flush lands during ISSUE.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_w && !bus.uart_send_busy && !bus.uart_div_wr && !div_guard) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_en && full_w) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    // div_guard blocks the cycle after a divider write, when simpleuart
    // would swallow a data write while launching its dummy frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_guard <= 1'b0;
            dat_we_q  <= 1'b0;
            dat_di_q  <= 8'h00;
        end else begin
            div_guard <= bus.uart_div_wr;
            dat_we_q  <= pop;
            if (pop) begin
                dat_di_q <= head_byte;
            end
        end
    end

    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.uart_dat_we = dat_we_q;
    assign bus.uart_dat_di = dat_di_q;
    assign bus.state       = state_q;

`ifdef UART_TX_FIFO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= empty_w && (state_q == IDLE) && !bus.uart_send_busy;
        end
    end

    assign bus.irq_tx_done = irq_q;
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer placed directly upstream of the `simpleuart` core. Bus writes land in a small byte FIFO. A drain state machine then presents each byte to the UART data-write port only when the UART transmitter is idle, so software can burst up to DEPTH bytes without polling `send_busy`. It also guards against the UART's divider-write dummy frame, which silently discards a data write issued in the cycle after a divider write.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, 2..256.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wr_en` in 1: bus push strobe, one byte per cycle.
- `wr_data` in 8: byte to push.
- `flush` in 1: synchronous FIFO clear.
- `clr_overflow` in 1: clears the sticky `overflow` flag.
- `full` out 1: FIFO holds DEPTH bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when a push is dropped.
- `uart_dat_we` out 1: registered one-cycle write strobe to the UART data port.
- `uart_dat_di` out 8: registered byte; valid while `uart_dat_we` is high.
- `uart_send_busy` in 1: UART `reg_status[1]`.
- `uart_div_wr` in 1: OR of the UART divider byte-write enables.
- `irq_tx_done` out 1: present only with `UART_TX_FIFO_IRQ_EN`.

## Operation
- Reset values: `full`=0, `empty`=1, `level`=0, `overflow`=0, `uart_dat_we`=0, `uart_dat_di`=0, `irq_tx_done`=0. Pointers are 0 and the state machine is in IDLE.
- Push:
  - When `wr_en` is high and the FIFO is not full, store `wr_data` at the write pointer and increment the pointer (wraps modulo DEPTH).
  - When `wr_en` is high and the FIFO is full, drop the byte and set `overflow`.
  - `full` is evaluated before any pop in the same cycle, so a push into a full FIFO is dropped even if a pop occurs that cycle.
- `level`:
  - +1 on an accepted push.
  - −1 on a pop.
  - Unchanged when both happen in the same cycle.
- `overflow`:
  - `clr_overflow` clears it.
  - If a set and a clear occur in the same cycle, set wins.
- `div_guard`: a one-cycle register that copies `uart_div_wr`. No data write may be issued in any cycle where `uart_div_wr` or `div_guard` is high.
- Drain state machine:
  - IDLE → ISSUE when the FIFO is not empty, `uart_send_busy`=0, `uart_div_wr`=0 and `div_guard`=0. On this transition, register the head byte into `uart_dat_di` and pop it.
  - ISSUE: `uart_dat_we`=1 for exactly this cycle; always → WAIT.
  - WAIT: one cycle, covering the UART's one-cycle busy latency; always → IDLE.
- `flush`:
  - Zeroes both pointers and `level`. `overflow` is unaffected.
  - A push in the same cycle as `flush` is discarded.
  - If the state machine is in ISSUE, the strobe still completes, because the byte has already been popped.
- Reset mid-frame: the FIFO and the state machine clear. A frame already inside the UART finishes on its own.

## Timing
- Push to strobe: push at edge n → `empty`=0 after edge n → state moves to ISSUE at edge n+1 → `uart_dat_we` is high in the cycle after edge n+1.
- Back-to-back bytes: the next ISSUE is no earlier than the first IDLE cycle in which `uart_send_busy`=0. The minimum spacing is 3 cycles plus the UART frame time.
- `level`, `full` and `empty` update on the edge after the push or pop.
- `uart_dat_we` is always a single-cycle pulse and is never high in two consecutive cycles.

## Configuration
- `UART_TX_FIFO_IRQ_EN` defined:
  - Adds the `irq_tx_done` port.
  - Registered level output, high while the FIFO is empty, the state machine is in IDLE and `uart_send_busy`=0.
  - Updates one cycle after the condition changes.
- Not defined:
  - No port and no logic.
  - Software polls `empty` and `uart_send_busy`.

## Structure
- Shared package `uart_pkg` holds:
  - The drain state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - The default FIFO depth constant.
- Sub-module `uart_fifo_mem`:
  - DEPTH×8 register array with one synchronous write port and an asynchronous read port at the read pointer.
  - Pointer, level and flag logic stay in `uart_tx_fifo`.

## Test plan
- Reset, then push 0x41 with `uart_send_busy`=0 → `uart_dat_we` pulses once, two cycles after the push edge, with `uart_dat_di`=0x41; `level` returns to 0.
- Push 0x10..0x13 back-to-back while `uart_send_busy` is held high → no strobe and `level`=4. Release busy, then hold it high for 20 cycles after each strobe → bytes go out in order 0x10,0x11,0x12,0x13 with no doubled strobes.
- With DEPTH=16 and busy held high, push 17 bytes → `full`=1, `level`=16, `overflow`=1, and the 17th byte is absent from the drain. Pulse `clr_overflow` → `overflow`=0.
- FIFO non-empty and UART idle; assert `uart_div_wr` for one cycle → no `uart_dat_we` in that cycle or the next. Raise busy from the model's dummy frame → the strobe appears only after busy falls.
- Push 5 bytes with busy high, then `flush` together with `wr_en`=1 (data 0x55) → `level`=0, `empty`=1, 0x55 is not stored, and no further strobes occur.
- Assert `reset` asynchronously mid-WAIT → all outputs reach reset values before the next edge. Drive without `UART_TX_FIFO_IRQ_EN` and confirm `irq_tx_done` is absent; drive with it defined and confirm `irq_tx_done`=1 after the final byte's busy falls.
